// File: rtl/switch_conditioner.sv
// Two-channel board-switch conditioner: each switch is synchronized, debounced by a
// 4-state pend/accept FSM, and gets single-cycle rise/fall pulses on accepted edges.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic right_raw,
    input  logic left_raw,
    output logic right,
    output logic left,
    output logic right_rise,
    output logic right_fall,
    output logic left_rise,
    output logic left_fall,
    output logic both_on
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        PEND_HI = 2'd1,
        IDLE_HI = 2'd2,
        PEND_LO = 2'd3
    } state_t;

    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;

    assign raw_vec = {left_raw, right_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sample;
            state_t                 state_reg, state_next;
            logic [CW-1:0]          cnt_reg, cnt_next;
            logic                   level_reg, level_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_vec[gi]};
                end
            end

            assign sample = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= IDLE_LO;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            // Entering a PEND state counts the first stable sample, so acceptance
            // happens on the DEBOUNCE_CYCLES-th consecutive sample at the new level.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                level_next = level_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                case (state_reg)
                    IDLE_LO: begin
                        if (sample) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_next = IDLE_HI;
                                level_next = 1'b1;
                                rise_next  = 1'b1;
                            end else begin
                                state_next = PEND_HI;
                                cnt_next   = CNT_ONE;
                            end
                        end
                    end
                    PEND_HI: begin
                        if (!sample) begin
                            state_next = IDLE_LO;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE_HI;
                            cnt_next   = '0;
                            level_next = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    IDLE_HI: begin
                        if (!sample) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_next = IDLE_LO;
                                level_next = 1'b0;
                                fall_next  = 1'b1;
                            end else begin
                                state_next = PEND_LO;
                                cnt_next   = CNT_ONE;
                            end
                        end
                    end
                    PEND_LO: begin
                        if (sample) begin
                            state_next = IDLE_HI;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE_LO;
                            cnt_next   = '0;
                            level_next = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = IDLE_LO;
                        cnt_next   = '0;
                        level_next = 1'b0;
                    end
                endcase
            end

            assign level_vec[gi] = level_reg;
            assign rise_vec[gi]  = rise_reg;
            assign fall_vec[gi]  = fall_reg;
        end
    endgenerate

    assign right      = level_vec[0];
    assign left       = level_vec[1];
    assign right_rise = rise_vec[0];
    assign right_fall = fall_vec[0];
    assign left_rise  = rise_vec[1];
    assign left_fall  = fall_vec[1];
    assign both_on    = level_vec[0] & level_vec[1];

endmodule

// File: tb/tb_switch_conditioner.sv
// Scenario bench for switch_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): expected
// output vectors are queued as stimulus is applied and compared after each clock edge.
module tb_switch_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic right_raw, left_raw;
    logic right, left, right_rise, right_fall, left_rise, left_fall, both_on;

    int checks = 0;
    int errors = 0;

    // {right, left, right_rise, right_fall, left_rise, left_fall, both_on}
    logic [6:0] sb[$];
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    assign obs_v = {right, left, right_rise, right_fall, left_rise, left_fall, both_on};

    switch_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .right_raw (right_raw),
        .left_raw  (left_raw),
        .right     (right),
        .left      (left),
        .right_rise(right_rise),
        .right_fall(right_fall),
        .left_rise (left_rise),
        .left_fall (left_fall),
        .both_on   (both_on)
    );

    always #50 clk = ~clk;

    function automatic logic [6:0] mk(bit r, bit l, bit rr, bit rf, bit lr, bit lf);
        return {r, l, rr, rf, lr, lf, r & l};
    endfunction

    task automatic test_reset();
        reset = 1'b1; right_raw = 1'b0; left_raw = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        right_raw = 1'b1; left_raw = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        #1;
        exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_async got %b expected %b", obs_v, exp_v);
        end
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL reset_hold cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        right_raw = 1'b0; left_raw = 1'b0;
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL reset_idle cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_rise();
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b1;
            sb.push_back(mk(i >= 6, 0, i == 6, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL clean_rise cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_fall();
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b0;
            sb.push_back(mk(i < 6, 0, 0, i == 6, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL fall cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 12; i++) begin
            left_raw = (i <= 3);
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL glitch cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern = 5'b10101;  // cycle 1 is bit 4
        for (int i = 1; i <= 14; i++) begin
            right_raw = (i <= 5) ? pattern[5-i] : 1'b1;
            sb.push_back(mk(i >= 10, 0, i == 10, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL bounce cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b0;
            sb.push_back(mk(i < 6, 0, 0, i == 6, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL bounce_release cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b1; left_raw = 1'b1;
            sb.push_back(mk(i >= 6, i >= 6, i == 6, 0, i == 6, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL simul_rise cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b0; left_raw = 1'b0;
            sb.push_back(mk(i < 6, i < 6, 0, i == 6, 0, i == 6));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL simul_fall cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_midcount();
        for (int i = 1; i <= 4; i++) begin
            right_raw = 1'b1;
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL midcount_pre cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL midcount_rst cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(mk(i >= 6, 0, i == 6, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL midcount_post cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            right_raw = 1'b0;
            sb.push_back(mk(i < 6, 0, 0, i == 6, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL midcount_fall cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    // Exactly DEBOUNCE_CYCLES samples high is accepted, then the fall lands at minimum spacing.
    task automatic test_back_to_back();
        for (int i = 1; i <= 14; i++) begin
            left_raw = (i <= 4);
            sb.push_back(mk(0, (i >= 6) && (i <= 9), 0, 0, i == 6, i == 10));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL back_to_back cycle %0d got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_fall();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEBOUNCE_CYCLES, 100000, consecutive stable samples required to accept a level change (10 ms at 10 MHz); minimum 1.
- SYNC_STAGES, 2, synchronizer flop depth; minimum 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, 10 MHz clock.
- reset, input, 1, asynchronous active-low reset.
- right_raw, input, 1, unsynchronized right board switch.
- left_raw, input, 1, unsynchronized left board switch.
- right, output, 1, debounced right level; feeds the mode FSM.
- left, output, 1, debounced left level; feeds the mode FSM.
- right_rise / right_fall, output, 1 each, single-cycle pulses on debounced right transitions.
- left_rise / left_fall, output, 1 each, single-cycle pulses on debounced left transitions.
- both_on, output, 1, right AND left (debounced).
REQ-003 Every output SHALL be driven directly from flops, except both_on, which is the AND of two flops.

Function
REQ-004 Each channel (right, left) SHALL be an independent, identical instance of the logic below; channels SHALL NOT share counters.
REQ-005 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the channel's sample s.
REQ-006 Each channel SHALL run a 4-state FSM:
- IDLE_LO: output 0.
- PEND_HI: output 0, counting.
- IDLE_HI: output 1.
- PEND_LO: output 1, counting.
REQ-007 IDLE_LO: s=1 -> PEND_HI, counter loads 1.
- Exception: if DEBOUNCE_CYCLES=1, go directly to IDLE_HI.
REQ-008 PEND_HI, counting:
- s=0 -> IDLE_LO and counter clears.
- s=1 and counter = DEBOUNCE_CYCLES-1 -> IDLE_HI, output set to 1, counter clears.
- Otherwise counter increments.
REQ-009 IDLE_HI and PEND_LO SHALL mirror REQ-007/REQ-008 with the polarity inverted.
REQ-010 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL never wrap.
REQ-011 Output latency SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES clk edges, measured from the first edge sampling a new raw level to the edge updating the debounced output, provided raw stays constant throughout.
REQ-012 A raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change and no edge pulse.
REQ-013 Edge pulses:
- *_rise SHALL be 1 for exactly one cycle, the same cycle the debounced output first reads 1.
- *_fall SHALL behave the same way for the first cycle reading 0.
- Otherwise each pulse SHALL be 0.
REQ-014 rise and fall of one channel SHALL never assert in the same cycle; the two channels MAY pulse in the same cycle.
REQ-015 Successive accepted transitions on one channel SHALL be at least DEBOUNCE_CYCLES cycles apart.

Reset
REQ-016 While reset=0, the following SHALL clear to 0 asynchronously:
- all synchronizer flops, counters and outputs;
- both FSMs, which SHALL enter IDLE_LO.
REQ-017 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted.
REQ-018 If a switch is already high when reset deasserts, the output SHALL rise after the REQ-011 latency, with the matching *_rise pulse.
REQ-019 Reset deassertion is externally synchronized to clk; this block SHALL NOT add a reset synchronizer.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-020 Clean rise: right_raw 0->1 and held -> right=1 and right_rise=1 for one cycle, exactly 6 edges later; left unaffected.
REQ-021 Glitch reject: left_raw high for 3 cycles then low -> left, left_rise and left_fall stay 0 throughout.
REQ-022 Bounce: right_raw toggles 1,0,1,0,1 at 1-cycle intervals, then held 1 -> exactly one right_rise, 6 edges after the final 0->1.
REQ-023 Simultaneous: both raws rise in the same cycle -> right_rise and left_rise are asserted in the same cycle, and both_on=1 from that cycle onward.
REQ-024 Reset mid-count: right_raw high 4 cycles, then reset=0 for 2 cycles while raw stays high -> outputs 0 during reset, then right rises 6 edges after the first post-reset edge.
REQ-025 Fall: from right=1, right_raw 1->0 and held -> right_fall pulses once and right=0 after 6 edges; right_rise stays 0.
